// File: rtl/load_store_queue_pkg.sv
// ----------------------------------------------------------------------------
// load_store_queue_pkg
// Shared constants for the load/store queue: RV32 load/store funct3 codes,
// the issue FSM state encoding, and the funct3 legality check used when an
// op reaches the head of the queue.
// ----------------------------------------------------------------------------
package load_store_queue_pkg;

  // RV32 load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32 store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Issue FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Any funct3 outside the RV32 load/store sets is dropped instead of issued.
  function automatic logic op_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsq_fifo.sv
// ----------------------------------------------------------------------------
// lsq_fifo
// Storage for the load/store queue: circular buffer with head/tail pointers
// and an occupancy count. The head entry is presented combinationally.
// Ports:
//   clk, reset       clock and asynchronous active-low reset
//   push, wdata      write wdata at the tail (caller guarantees not full)
//   pop              advance the head (caller guarantees not empty)
//   flush            empty the queue at the next edge
//   rdata            current head entry
//   full, empty      occupancy flags from the registered count
// ----------------------------------------------------------------------------
module lsq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;

  // Entry storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count carries
  // one extra bit so that full and empty are distinguishable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/load_store_queue.sv
// ----------------------------------------------------------------------------
// load_store_queue
// In-order load/store queue in front of DataMemory. Buffers memory ops,
// issues at most one per cycle as a single-cycle strobe, captures load data
// into a one-entry result slot and returns it tagged under back-pressure.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   enq_*                       op offered by dispatch, enq_ready = not full
//   flush                       squash queued ops and any pending result
//   Load_Done / EX_MEM_MemWrite load / store issue strobes to DataMemory
//   EX_MEM_funct3/ALUResult/Rdata2  issued op fields (0 when not issuing)
//   Load_Data                   combinational read data from DataMemory
//   res_valid/res_ready/res_tag/res_data  tagged load result handshake
//   bad_op                      one-cycle pulse when an illegal op is dropped
// ----------------------------------------------------------------------------
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic             enq_is_store,
  input  logic [2:0]       enq_funct3,
  input  logic [31:0]      enq_addr,
  input  logic [31:0]      enq_wdata,
  input  logic [TAG_W-1:0] enq_tag,
  input  logic             flush,
  output logic             Load_Done,
  output logic             EX_MEM_MemWrite,
  output logic [2:0]       EX_MEM_funct3,
  output logic [31:0]      EX_MEM_ALUResult,
  output logic [31:0]      EX_MEM_Rdata2,
  input  logic [31:0]      Load_Data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic             bad_op
);

  localparam int ENTRY_W = 1 + 3 + 32 + 32 + TAG_W;

  logic [ENTRY_W-1:0] head_entry;
  logic               head_store;
  logic [2:0]         head_f3;
  logic [31:0]        head_addr;
  logic [31:0]        head_wdata;
  logic [TAG_W-1:0]   head_tag;
  logic               head_legal;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               load_ok;
  logic               issue_load;
  logic               issue_store;
  logic               drop_bad;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic               iss_load;
  logic               iss_store;
  logic [2:0]         iss_funct3;
  logic [31:0]        iss_addr;
  logic [31:0]        iss_wdata;
  logic [TAG_W-1:0]   iss_tag;

  assign enq_ready = !full;
  assign push      = enq_valid && enq_ready && !flush;

  lsq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({enq_is_store, enq_funct3, enq_addr, enq_wdata, enq_tag}),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  assign {head_store, head_f3, head_addr, head_wdata, head_tag} = head_entry;
  assign head_legal = op_legal(head_store, head_f3);

  // A load may only issue if the result slot will be free after this edge:
  // a load already strobing claims the slot now, and a held result must be
  // draining on the same edge.
  assign load_ok     = !Load_Done && (!res_valid || res_ready);
  assign issue_load  = !empty && !flush && head_legal && !head_store && load_ok;
  assign issue_store = !empty && !flush && head_legal && head_store;
  assign drop_bad    = !empty && !flush && !head_legal;
  assign pop         = issue_load || issue_store || drop_bad;

  always_comb begin
    next_state = ST_IDLE;
    if (issue_load || issue_store)
      next_state = ST_ISSUE;
    else if (!empty && !flush && !pop)
      next_state = ST_HOLD;
  end

  // Issue registers are cleared whenever nothing issues, so the memory-side
  // fields read as zero outside the strobe cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      iss_load   <= 1'b0;
      iss_store  <= 1'b0;
      iss_funct3 <= '0;
      iss_addr   <= '0;
      iss_wdata  <= '0;
      iss_tag    <= '0;
      bad_op     <= 1'b0;
    end else begin
      state      <= next_state;
      iss_load   <= issue_load;
      iss_store  <= issue_store;
      iss_funct3 <= (issue_load || issue_store) ? head_f3 : 3'b000;
      iss_addr   <= (issue_load || issue_store) ? head_addr : 32'h0;
      iss_wdata  <= issue_store ? head_wdata : 32'h0;
      iss_tag    <= issue_load ? head_tag : '0;
      bad_op     <= drop_bad;
    end
  end

  assign Load_Done        = (state == ST_ISSUE) && iss_load;
  assign EX_MEM_MemWrite  = (state == ST_ISSUE) && iss_store;
  assign EX_MEM_funct3    = iss_funct3;
  assign EX_MEM_ALUResult = iss_addr;
  assign EX_MEM_Rdata2    = iss_wdata;

  // Result slot: capture read data at the end of the Load_Done cycle, hold
  // until accepted. A flush discards both a held result and one in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (Load_Done) begin
      res_valid <= 1'b1;
      res_tag   <= iss_tag;
      res_data  <= Load_Data;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
